// File: rtl/wb_trace_fifo.sv
// Write-back trace FIFO: captures committed register-file writes {addr, data, pc}
// and presents them first-word fall-through on a valid/ready drain port.
module wb_trace_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PTR_W  = 4,
  parameter int unsigned DROP_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_valid_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [31:0]       wb_data_i,
  input  logic [31:0]       wb_pc_i,
  output logic              tr_valid_o,
  input  logic              tr_ready_i,
  output logic [4:0]        tr_addr_o,
  output logic [31:0]       tr_data_o,
  output logic [31:0]       tr_pc_o,
  output logic [PTR_W:0]    count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              overflow_o,
  input  logic              clr_i
);

  if ((DEPTH != (1 << PTR_W)) || (DEPTH < 2)) begin : g_bad_depth
    $error("wb_trace_fifo: DEPTH must be a power of two >= 2 and equal 2**PTR_W");
  end

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q,  count_d;
  logic [DROP_W-1:0] drop_q,   drop_d;
  logic              ovf_q,    ovf_d;

  logic empty, full;
  logic push_req, push_acc, pop, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  // Writes to $0 never reach the register file, so they are not trace events.
  assign push_req = wb_valid_i && (wb_addr_i != 5'd0);
  assign pop      = !empty && tr_ready_i;
  // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts.
  assign push_acc = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;

    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + (PTR_W+1)'(push_acc) - (PTR_W+1)'(pop);

    if (clr_i) begin
      drop_d = '0;
      ovf_d  = 1'b0;
    end else if (drop) begin
      if (!(&drop_q)) drop_d = drop_q + DROP_W'(1);
      ovf_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage has no reset; stale entries are unreachable once the pointers and count clear.
  always_ff @(posedge clk_i) begin
    if (rst_i && push_acc) begin
      mem_q[wr_ptr_q] <= '{addr: wb_addr_i, data: wb_data_i, pc: wb_pc_i};
    end
  end

  entry_t head;
  always_comb begin
    head = '0;
    if (!empty) head = mem_q[rd_ptr_q];
  end

  assign tr_valid_o = !empty;
  assign tr_addr_o  = head.addr;
  assign tr_data_o  = head.data;
  assign tr_pc_o    = head.pc;
  assign count_o    = count_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign drop_cnt_o = drop_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_wb_trace_fifo;

  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;
  localparam int DROP_W = 16;
  localparam int VW     = 1 + 5 + 32 + 32 + (PTR_W + 1) + 1 + 1 + DROP_W + 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              wb_valid_i = 1'b0;
  logic [4:0]        wb_addr_i = '0;
  logic [31:0]       wb_data_i = '0;
  logic [31:0]       wb_pc_i = '0;
  logic              tr_valid_o;
  logic              tr_ready_i = 1'b0;
  logic [4:0]        tr_addr_o;
  logic [31:0]       tr_data_o;
  logic [31:0]       tr_pc_o;
  logic [PTR_W:0]    count_o;
  logic              full_o;
  logic              empty_o;
  logic [DROP_W-1:0] drop_cnt_o;
  logic              overflow_o;
  logic              clr_i = 1'b0;

  wb_trace_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DROP_W(DROP_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_pc_i(wb_pc_i),
    .tr_valid_o(tr_valid_o), .tr_ready_i(tr_ready_i),
    .tr_addr_o(tr_addr_o), .tr_data_o(tr_data_o), .tr_pc_o(tr_pc_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o), .clr_i(clr_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of pending writes plus the drop bookkeeping.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  ent_t q[$];
  int   m_drops = 0;
  bit   m_ovf   = 0;
  ent_t last_pop;

  function automatic logic [VW-1:0] model_vec();
    ent_t h = '0;
    int   n = q.size();
    if (n > 0) h = q[0];
    return {n > 0, h.a, h.d, h.p, (PTR_W+1)'(n), n == DEPTH, n == 0,
            DROP_W'(m_drops), m_ovf};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {tr_valid_o, tr_addr_o, tr_data_o, tr_pc_o, count_o, full_o, empty_o,
            drop_cnt_o, overflow_o};
  endfunction

  // Apply the inputs present at this edge to the model.
  task automatic model_edge();
    bit do_pop, do_push, dropped;
    if (!rst_i) begin
      q.delete();
      m_drops = 0;
      m_ovf   = 0;
      return;
    end
    do_pop  = (q.size() > 0) && tr_ready_i;
    do_push = wb_valid_i && (wb_addr_i != 0);
    dropped = do_push && (q.size() == DEPTH) && !do_pop;
    if (do_pop) last_pop = q.pop_front();
    if (do_push && !dropped) q.push_back('{a: wb_addr_i, d: wb_data_i, p: wb_pc_i});
    if (clr_i) begin
      m_drops = 0;
      m_ovf   = 0;
    end else if (dropped) begin
      if (m_drops != (1 << DROP_W) - 1) m_drops++;
      m_ovf = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] p, input bit r, input bit c);
    wb_valid_i = v; wb_addr_i = a; wb_data_i = d; wb_pc_i = p;
    tr_ready_i = r; clr_i = c;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_i = 0;
    idle();
    tick(); tick();
    rst_i = 1;
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), model_vec());
    end
    n_checks++;
    if (tr_valid_o !== 1'b0 || empty_o !== 1'b1 || full_o !== 1'b0 ||
        drop_cnt_o !== '0 || overflow_o !== 1'b0 || count_o !== '0) begin
      n_errors++;
      $display("FAIL reset_flags: valid=%b empty=%b full=%b drop=%0d ovf=%b count=%0d expected 0 1 0 0 0 0",
               tr_valid_o, empty_o, full_o, drop_cnt_o, overflow_o, count_o);
    end
  endtask

  task automatic test_basic();
    drive(1, 5'd8, 32'h0000_0005, 32'h0, 0, 0);
    tick();
    n_checks++;
    if (tr_valid_o !== 1'b1 || tr_addr_o !== 5'd8) begin
      n_errors++;
      $display("FAIL basic_latency: valid=%b addr=%0d expected 1 8", tr_valid_o, tr_addr_o);
    end
    drive(1, 5'd9, 32'hFFFF_FFFB, 32'h4, 0, 0);
    tick();
    idle();
    n_checks++;
    if (count_o !== 5'd2 || tr_addr_o !== 5'd8 || tr_data_o !== 32'h5 || tr_pc_o !== 32'h0) begin
      n_errors++;
      $display("FAIL basic_head: count=%0d addr=%0d data=%h pc=%h expected 2 8 00000005 00000000",
               count_o, tr_addr_o, tr_data_o, tr_pc_o);
    end
    tr_ready_i = 1;
    tick();
    n_checks++;
    if (tr_addr_o !== 5'd9 || tr_data_o !== 32'hFFFF_FFFB || tr_pc_o !== 32'h4 || count_o !== 5'd1) begin
      n_errors++;
      $display("FAIL basic_second: addr=%0d data=%h pc=%h count=%0d expected 9 fffffffb 00000004 1",
               tr_addr_o, tr_data_o, tr_pc_o, count_o);
    end
    tick();
    idle();
    n_checks++;
    if (empty_o !== 1'b1 || tr_valid_o !== 1'b0 || tr_addr_o !== '0 || tr_data_o !== '0 || tr_pc_o !== '0) begin
      n_errors++;
      $display("FAIL basic_empty: empty=%b valid=%b addr=%0d data=%h pc=%h expected 1 0 0 0 0",
               empty_o, tr_valid_o, tr_addr_o, tr_data_o, tr_pc_o);
    end
    // Ready while empty must not disturb anything.
    tr_ready_i = 1;
    tick();
    idle();
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_errors++;
      $display("FAIL ready_when_empty: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_zero_addr();
    drive(1, 5'd0, 32'h1234, 32'h8, 0, 0);
    tick();
    idle();
    n_checks++;
    if (count_o !== '0 || drop_cnt_o !== '0 || tr_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_addr: count=%0d drop=%0d valid=%b expected 0 0 0", count_o, drop_cnt_o, tr_valid_o);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive(1, 5'(i + 1), $urandom, 32'(i * 4), 0, 0);
      tick();
      if (i == DEPTH - 1) begin
        n_checks++;
        if (full_o !== 1'b1 || count_o !== 5'd16 || overflow_o !== 1'b0) begin
          n_errors++;
          $display("FAIL overflow_full: full=%b count=%0d ovf=%b expected 1 16 0", full_o, count_o, overflow_o);
        end
      end
    end
    idle();
    n_checks++;
    if (full_o !== 1'b1 || drop_cnt_o !== 16'd3 || overflow_o !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_drops: full=%b drop=%0d ovf=%b expected 1 3 1", full_o, drop_cnt_o, overflow_o);
    end
    tr_ready_i = 1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (tr_addr_o !== 5'(i + 1) || tr_pc_o !== 32'(i * 4) || dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL overflow_drain[%0d]: addr=%0d pc=%h expected %0d %h", i, tr_addr_o, tr_pc_o, i + 1, i * 4);
      end
      tick();
    end
    idle();
    n_checks++;
    if (empty_o !== 1'b1 || drop_cnt_o !== 16'd3) begin
      n_errors++;
      $display("FAIL overflow_after: empty=%b drop=%0d expected 1 3", empty_o, drop_cnt_o);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 5'(i + 10), 32'(i), 32'h100 + 32'(i), 0, 0);
      tick();
    end
    drive(1, 5'd31, 32'hDEAD_BEEF, 32'h200, 1, 0);
    tick();
    idle();
    n_checks++;
    if (count_o !== 5'd16 || drop_cnt_o !== 16'd3 || full_o !== 1'b1) begin
      n_errors++;
      $display("FAIL full_push_pop: count=%0d drop=%0d full=%b expected 16 3 1", count_o, drop_cnt_o, full_o);
    end
    tr_ready_i = 1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      n_checks++;
      if (last_pop !== (i == DEPTH - 1 ? ent_t'{a: 5'd31, d: 32'hDEAD_BEEF, p: 32'h200}
                                       : ent_t'{a: 5'(i + 11), d: 32'(i + 1), p: 32'h101 + 32'(i)})) begin
        n_errors++;
        $display("FAIL full_push_pop_order[%0d]: model popped %h", i, last_pop);
      end
    end
    idle();
    n_checks++;
    if (empty_o !== 1'b1 || dut_vec() !== model_vec()) begin
      n_errors++;
      $display("FAIL full_push_pop_empty: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1, 5'd3, 32'(i), 32'(i), 0, 0);
      tick();
    end
    idle();
    n_checks++;
    if (drop_cnt_o !== 16'd5 || overflow_o !== 1'b1) begin
      n_errors++;
      $display("FAIL clr_setup: drop=%0d ovf=%b expected 5 1", drop_cnt_o, overflow_o);
    end
    drive(1, 5'd4, 32'hAAAA, 32'hBBBB, 0, 1);
    tick();
    idle();
    n_checks++;
    if (drop_cnt_o !== '0 || overflow_o !== 1'b0 || count_o !== 5'd16) begin
      n_errors++;
      $display("FAIL clr_wins: drop=%0d ovf=%b count=%0d expected 0 0 16", drop_cnt_o, overflow_o, count_o);
    end
  endtask

  task automatic test_mid_reset();
    tr_ready_i = 1;
    repeat (DEPTH - 10) tick();
    idle();
    n_checks++;
    if (count_o !== 5'd10) begin
      n_errors++;
      $display("FAIL mid_reset_setup: count=%0d expected 10", count_o);
    end
    drive(1, 5'd5, 32'h55, 32'h66, 1, 0);
    rst_i = 0;
    tick();
    rst_i = 1;
    idle();
    n_checks++;
    if (count_o !== '0 || tr_valid_o !== 1'b0 || drop_cnt_o !== '0 || empty_o !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset: count=%0d valid=%b drop=%0d empty=%b expected 0 0 0 1",
               count_o, tr_valid_o, drop_cnt_o, empty_o);
    end
    drive(1, 5'd2, 32'h7, 32'h40, 0, 0);
    tick();
    idle();
    n_checks++;
    if (count_o !== 5'd1 || tr_addr_o !== 5'd2 || tr_data_o !== 32'h7 || tr_pc_o !== 32'h40) begin
      n_errors++;
      $display("FAIL mid_reset_next: count=%0d addr=%0d data=%h pc=%h expected 1 2 00000007 00000040",
               count_o, tr_addr_o, tr_data_o, tr_pc_o);
    end
  endtask

  task automatic test_random();
    int errs_before = n_errors;
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 7, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom, $urandom_range(0, 9) < (i < 750 ? 3 : 7),
            $urandom_range(0, 49) == 0);
      rst_i = ($urandom_range(0, 299) != 0);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++;
        if (n_errors - errs_before <= 10)
          $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    rst_i = 1;
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_basic();
    test_zero_addr();
    test_overflow();
    test_full_push_pop();
    test_clr();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
- Downstream consumer of the single-cycle CPU's register write-back path.
- Captures every committed register-file write into a FIFO: destination address, write data, and the PC of the writing instruction.
- Presents captured writes on a valid/ready drain port, for bench scoreboards or a debug UART.
- Counts writes it had to discard, so that a lost trace is detectable.

Parameters:
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- PTR_W, 4, log2(DEPTH); the pointer width.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous active-low reset (rst_i==0 at a rising edge resets).
- wb_valid_i  input  1  register write committed this cycle (final RegWrite after the jr gating).
- wb_addr_i  input  5  destination register (final write-address mux output).
- wb_data_i  input  32  write-back data (final write-data mux output).
- wb_pc_i  input  32  PC of the writing instruction.
- tr_valid_o  output  1  head entry available.
- tr_ready_i  input  1  consumer accepts head entry.
- tr_addr_o  output  5  head entry address; 0 when empty.
- tr_data_o  output  32  head entry data; 0 when empty.
- tr_pc_o  output  32  head entry PC; 0 when empty.
- count_o  output  PTR_W+1  occupancy, 0..DEPTH.
- full_o  output  1  count_o==DEPTH.
- empty_o  output  1  count_o==0.
- drop_cnt_o  output  DROP_W  number of discarded writes; saturates at all-ones.
- overflow_o  output  1  sticky flag, set on any drop.
- clr_i  input  1  clears drop_cnt_o and overflow_o; FIFO contents untouched.

Behaviour:
- Reset (rst_i==0 at an edge):
  - Read/write pointers and count go to 0.
  - tr_valid_o=0, empty_o=1, full_o=0, drop_cnt_o=0, overflow_o=0.
  - Storage array is not cleared.
  - Reset overrides every other input in the same cycle.
- Reset mid-operation: all entries are discarded, with no drain of pending data.
- Push request: wb_valid_i==1 and wb_addr_i!=0.
  - Writes to $0 are silently ignored and are not counted as drops.
- Pop: tr_valid_o && tr_ready_i at an edge; the read pointer advances.
- Drain port is first-word fall-through:
  - tr_valid_o = ~empty_o.
  - tr_* outputs are driven combinationally from the storage entry at the read pointer, forced to 0 when empty.
- Latency: an entry pushed at edge N appears at the head (if the FIFO was empty) during the cycle after edge N. It is popped no earlier than edge N+1.
- Not full: push writes {addr, data, pc} at the write pointer, and the write pointer increments.
- Full, no pop in the same cycle: the push is dropped.
  - drop_cnt_o increments unless already all-ones.
  - overflow_o is set.
- Full with a pop in the same cycle: both the push and the pop occur, count stays DEPTH, nothing is dropped.
- Empty with a push: the pop is impossible that cycle (tr_valid_o=0), so count becomes 1.
- Push and pop together when neither empty nor full: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- count_o, full_o and empty_o are registered and derived from count, with no combinational path from wb_valid_i.
- clr_i at an edge: drop_cnt_o goes to 0 and overflow_o to 0. A drop in the same cycle is not counted, so clr wins.
- tr_ready_i while empty has no effect.
- Entry order is strictly preserved; no entry is ever duplicated.

Test Plan:
- Reset, then pushes (addr=8, data=0x0000_0005, pc=0x0) and (addr=9, data=0xFFFF_FFFB, pc=0x4), with tr_ready_i=0:
  - count_o=2, and the head reads addr 8 / data 0x5.
  - Raise ready for 2 cycles: the entries emerge in order, then empty_o=1 and tr_*=0.
- Push with wb_addr_i=0, data 0x1234:
  - count_o stays 0 and drop_cnt_o stays 0.
- 16 pushes with ready=0, then 3 more pushes:
  - full_o=1, drop_cnt_o=3, overflow_o=1.
  - Draining returns exactly the first 16 entries.
- Full FIFO, push (addr=31, data=0xDEAD_BEEF) and ready=1 in the same cycle:
  - No drop and count stays 16.
  - The new entry is the 16th popped thereafter.
- overflow_o=1 and drop_cnt_o=5, then clr_i=1 with a simultaneous dropped push:
  - drop_cnt_o=0 and overflow_o=0 after the edge.
- 10 entries queued, rst_i=0 for one cycle with push and ready both active:
  - count_o=0, tr_valid_o=0, drop_cnt_o=0.
  - Next push (addr=2, data=0x7) appears as the sole head entry.
